// File: rtl/universal_shift_reg.sv
// universal_shift_reg: parametrised bidirectional shift/rotate register with parallel load and frame counter
//   i_clk        rising-edge clock
//   i_reset      asynchronous active-low reset
//   i_en         clock enable; all state holds when low
//   i_mode       00 hold, 01 shift right, 10 shift left, 11 parallel load
//   i_rotate     feed the outgoing bit back instead of i_sin
//   i_sin        serial data in
//   i_pin        parallel load data
//   o_q          register contents
//   o_sout       bit the next shift will drop (combinational)
//   o_shift_cnt  shifts completed in the current frame
//   o_frame_done one-cycle pulse after the WIDTH-th shift of a frame
module universal_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CW        = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic             i_rotate,
    input  logic             i_sin,
    input  logic [WIDTH-1:0] i_pin,
    output logic [WIDTH-1:0] o_q,
    output logic             o_sout,
    output logic [CW-1:0]    o_shift_cnt,
    output logic             o_frame_done
);
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic             w_shift;
    logic             w_load;
    logic             w_last;
    logic             w_in_bit;
    logic [WIDTH-1:0] w_q_next;
    logic [CW-1:0]    w_cnt_next;

    assign o_sout   = (i_mode == 2'b10) ? r_q[WIDTH-1] : r_q[0];
    assign w_shift  = i_en && (i_mode == 2'b01 || i_mode == 2'b10);
    assign w_load   = i_en && (i_mode == 2'b11);
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    // the dropped bit is exactly o_sout in either shift direction
    assign w_in_bit = i_rotate ? o_sout : i_sin;

    always_comb begin
        w_q_next   = !i_en              ? r_q :
                     i_mode == 2'b01    ? {w_in_bit, r_q[WIDTH-1:1]} :
                     i_mode == 2'b10    ? {r_q[WIDTH-2:0], w_in_bit} :
                     i_mode == 2'b11    ? i_pin : r_q;
        w_cnt_next = w_load  ? '0 :
                     w_shift ? (w_last ? '0 : r_cnt + 1'b1) : r_cnt;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_q    <= RESET_VAL;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_cnt  <= w_cnt_next;
            r_done <= w_shift && w_last;
        end
    end

    assign o_q          = r_q;
    assign o_shift_cnt  = r_cnt;
    assign o_frame_done = r_done;
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: scoreboard bench for universal_shift_reg at WIDTH 8, 2 and 16
module tb_universal_shift_reg;
    typedef struct {
        logic [15:0] q;
        logic [3:0]  cnt;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       en8, rot8, sin8, sout8, done8;
    logic [1:0] mode8;
    logic [7:0] pin8, q8;
    logic [2:0] cnt8;

    logic       en2, rot2, sin2, sout2, done2;
    logic [1:0] mode2, pin2, q2;
    logic [0:0] cnt2;

    logic        en16, rot16, sin16, sout16, done16;
    logic [1:0]  mode16;
    logic [15:0] pin16, q16;
    logic [3:0]  cnt16;

    universal_shift_reg #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_reset(rst_n), .i_en(en8), .i_mode(mode8), .i_rotate(rot8),
        .i_sin(sin8), .i_pin(pin8), .o_q(q8), .o_sout(sout8), .o_shift_cnt(cnt8),
        .o_frame_done(done8));
    universal_shift_reg #(.WIDTH(2)) dut2 (
        .i_clk(clk), .i_reset(rst_n), .i_en(en2), .i_mode(mode2), .i_rotate(rot2),
        .i_sin(sin2), .i_pin(pin2), .o_q(q2), .o_sout(sout2), .o_shift_cnt(cnt2),
        .o_frame_done(done2));
    universal_shift_reg #(.WIDTH(16)) dut16 (
        .i_clk(clk), .i_reset(rst_n), .i_en(en16), .i_mode(mode16), .i_rotate(rot16),
        .i_sin(sin16), .i_pin(pin16), .o_q(q16), .o_sout(sout16), .o_shift_cnt(cnt16),
        .o_frame_done(done16));

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb8[$];
    exp_t sb2[$];
    exp_t sb16[$];
    logic [7:0] m_q;
    logic [2:0] m_cnt;
    logic       m_done;

    // WIDTH=8: behavioural model predicts the next state, pushed before the edge, popped after it
    task automatic step8(input logic en, input logic [1:0] mode, input logic rot, input logic sin,
                         input logic [7:0] pin, output logic so);
        exp_t e;
        logic ib, sh, exp_so;
        en8 = en; mode8 = mode; rot8 = rot; sin8 = sin; pin8 = pin;
        exp_so = (mode == 2'b10) ? m_q[7] : m_q[0];
        ib = rot ? exp_so : sin;
        sh = en && (mode == 2'b01 || mode == 2'b10);
        if (en && mode == 2'b01) m_q = {ib, m_q[7:1]};
        else if (en && mode == 2'b10) m_q = {m_q[6:0], ib};
        else if (en && mode == 2'b11) m_q = pin;
        m_done = sh && (m_cnt == 3'd7);
        if (en && mode == 2'b11) m_cnt = 3'd0;
        else if (sh) m_cnt = (m_cnt == 3'd7) ? 3'd0 : m_cnt + 3'd1;
        e.q = {8'h00, m_q}; e.cnt = {1'b0, m_cnt}; e.done = m_done;
        sb8.push_back(e);
        #1;
        so = sout8;
        n_checks++;
        if (sout8 !== exp_so) begin
            n_errors++;
            $display("FAIL sout8 got %b expected %b", sout8, exp_so);
        end
        @(posedge clk); #1;
        e = sb8.pop_front();
        n_checks++;
        if (q8 !== e.q[7:0] || cnt8 !== e.cnt[2:0] || done8 !== e.done) begin
            n_errors++;
            $display("FAIL state8 got q=%h cnt=%0d done=%b expected q=%h cnt=%0d done=%b",
                     q8, cnt8, done8, e.q[7:0], e.cnt[2:0], e.done);
        end
    endtask

    // WIDTH=2 and 16: caller supplies the expected post-edge state
    task automatic step2(input logic [1:0] mode, input logic rot, input logic sin, input logic [1:0] pin,
                         input logic [1:0] eq, input logic ec, input logic ed);
        exp_t e;
        en2 = 1'b1; mode2 = mode; rot2 = rot; sin2 = sin; pin2 = pin;
        e.q = {14'h0, eq}; e.cnt = {3'b0, ec}; e.done = ed;
        sb2.push_back(e);
        @(posedge clk); #1;
        e = sb2.pop_front();
        n_checks++;
        if (q2 !== e.q[1:0] || cnt2 !== e.cnt[0:0] || done2 !== e.done) begin
            n_errors++;
            $display("FAIL state2 got q=%b cnt=%0d done=%b expected q=%b cnt=%0d done=%b",
                     q2, cnt2, done2, e.q[1:0], e.cnt[0], e.done);
        end
    endtask

    task automatic step16(input logic [1:0] mode, input logic sin,
                          input logic [15:0] eq, input logic [3:0] ec, input logic ed);
        exp_t e;
        en16 = 1'b1; mode16 = mode; rot16 = 1'b0; sin16 = sin; pin16 = 16'h0;
        e.q = eq; e.cnt = ec; e.done = ed;
        sb16.push_back(e);
        @(posedge clk); #1;
        e = sb16.pop_front();
        n_checks++;
        if (q16 !== e.q || cnt16 !== e.cnt || done16 !== e.done) begin
            n_errors++;
            $display("FAIL state16 got q=%h cnt=%0d done=%b expected q=%h cnt=%0d done=%b",
                     q16, cnt16, done16, e.q, e.cnt, e.done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en8 = 0; mode8 = 0; rot8 = 0; sin8 = 0; pin8 = 0;
        en2 = 0; mode2 = 0; rot2 = 0; sin2 = 0; pin2 = 0;
        en16 = 0; mode16 = 0; rot16 = 0; sin16 = 0; pin16 = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (q8 !== 8'h00 || cnt8 !== 3'd0 || done8 !== 1'b0 || q2 !== 2'b00 || q16 !== 16'h0) begin
            n_errors++;
            $display("FAIL reset got q8=%h cnt8=%0d done8=%b q2=%b q16=%h", q8, cnt8, done8, q2, q16);
        end
        rst_n = 1'b1;
        m_q = 8'h00; m_cnt = 3'd0; m_done = 1'b0;
    endtask

    task automatic test_fill();
        logic [7:0] seq [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
        logic so;
        for (int i = 0; i < 8; i++) begin
            step8(1, 2'b01, 0, 1, 8'h00, so);
            n_checks++;
            if (q8 !== seq[i] || done8 !== (i == 7)) begin
                n_errors++;
                $display("FAIL fill[%0d] got q=%h done=%b expected q=%h done=%b", i, q8, done8, seq[i], i == 7);
            end
        end
        n_checks++;
        if (cnt8 !== 3'd0) begin
            n_errors++;
            $display("FAIL fill_cnt got %0d expected 0", cnt8);
        end
        step8(1, 2'b00, 0, 0, 8'h00, so);
    endtask

    task automatic test_serialise();
        logic [7:0] bits = 8'b10100101;
        logic so;
        step8(1, 2'b11, 0, 0, 8'hA5, so);
        for (int i = 0; i < 8; i++) begin
            step8(1, 2'b01, 0, 0, 8'h00, so);
            n_checks++;
            if (so !== bits[i]) begin
                n_errors++;
                $display("FAIL serial_bit[%0d] got %b expected %b", i, so, bits[i]);
            end
        end
        n_checks++;
        if (q8 !== 8'h00) begin
            n_errors++;
            $display("FAIL serial_final got %h expected 00", q8);
        end
    endtask

    task automatic test_rotate();
        logic so;
        int pulses = 0;
        step8(1, 2'b11, 0, 0, 8'h81, so);
        step8(1, 2'b10, 1, 0, 8'h00, so);
        n_checks++;
        if (q8 !== 8'h03) begin
            n_errors++;
            $display("FAIL rot_first got %h expected 03", q8);
        end
        pulses += done8;
        for (int i = 0; i < 7; i++) begin
            step8(1, 2'b10, 1, 1, 8'h00, so);
            pulses += done8;
        end
        n_checks++;
        if (q8 !== 8'h81 || pulses != 1) begin
            n_errors++;
            $display("FAIL rot_full got q=%h pulses=%0d expected q=81 pulses=1", q8, pulses);
        end
    endtask

    task automatic test_enable();
        logic so;
        logic [7:0] held;
        step8(1, 2'b11, 0, 0, 8'h3C, so);
        for (int i = 0; i < 3; i++) step8(1, 2'b01, 0, 1'($urandom_range(1)), 8'h00, so);
        held = q8;
        for (int i = 0; i < 5; i++) begin
            step8(0, 2'(i % 4), 0, 1, 8'hFF, so);
            n_checks++;
            if (q8 !== held || cnt8 !== 3'd3 || done8 !== 1'b0) begin
                n_errors++;
                $display("FAIL en_hold got q=%h cnt=%0d done=%b expected q=%h cnt=3 done=0", q8, cnt8, done8, held);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step8(1, 2'b01, 0, 1'($urandom_range(1)), 8'h00, so);
            n_checks++;
            if (done8 !== (i == 4)) begin
                n_errors++;
                $display("FAIL en_done[%0d] got %b expected %b", i, done8, i == 4);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic so;
        int pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step8(1, (i % 3 == 0) ? 2'b10 : 2'b01, 1'($urandom_range(1)), 1'($urandom_range(1)), 8'h00, so);
            pulses += done8;
            n_checks++;
            if (done8 !== (i % 8 == 7)) begin
                n_errors++;
                $display("FAIL b2b_done[%0d] got %b expected %b", i, done8, i % 8 == 7);
            end
        end
        n_checks++;
        if (pulses != 2) begin
            n_errors++;
            $display("FAIL b2b_pulses got %0d expected 2", pulses);
        end
    endtask

    task automatic test_abort_reset();
        logic so;
        for (int i = 0; i < 4; i++) step8(1, 2'b01, 0, 1, 8'h00, so);
        step8(1, 2'b11, 0, 0, 8'h55, so);
        n_checks++;
        if (cnt8 !== 3'd0 || done8 !== 1'b0 || q8 !== 8'h55) begin
            n_errors++;
            $display("FAIL abort got q=%h cnt=%0d done=%b expected q=55 cnt=0 done=0", q8, cnt8, done8);
        end
        for (int i = 0; i < 2; i++) step8(1, 2'b01, 0, 1, 8'h00, so);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (q8 !== 8'h00 || cnt8 !== 3'd0 || done8 !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset got q=%h cnt=%0d done=%b expected q=00 cnt=0 done=0", q8, cnt8, done8);
        end
        en8 = 1; mode8 = 2'b11; pin8 = 8'hFF;
        @(posedge clk); #1;
        n_checks++;
        if (q8 !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_held got q=%h expected 00", q8);
        end
        rst_n = 1'b1;
        m_q = 8'h00; m_cnt = 3'd0; m_done = 1'b0;
        step8(1, 2'b01, 0, 1, 8'h00, so);
    endtask

    task automatic test_width2();
        step2(2'b01, 0, 1, 2'b00, 2'b10, 1'b1, 1'b0);
        step2(2'b01, 0, 1, 2'b00, 2'b11, 1'b0, 1'b1);
        step2(2'b01, 0, 0, 2'b00, 2'b01, 1'b1, 1'b0);
        step2(2'b01, 0, 0, 2'b00, 2'b00, 1'b0, 1'b1);
        step2(2'b11, 0, 0, 2'b01, 2'b01, 1'b0, 1'b0);
        step2(2'b10, 1, 0, 2'b00, 2'b10, 1'b1, 1'b0);
        step2(2'b10, 1, 0, 2'b00, 2'b01, 1'b0, 1'b1);
        step2(2'b00, 0, 0, 2'b00, 2'b01, 1'b0, 1'b0);
        en2 = 1'b0;
    endtask

    task automatic test_width16();
        logic [15:0] eq = 16'h0;
        for (int k = 1; k <= 32; k++) begin
            eq = {1'b1, eq[15:1]};
            step16(2'b01, 1, eq, 4'(k % 16), (k % 16) == 0);
        end
        en16 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_serialise();
        test_rotate();
        test_enable();
        test_back_to_back();
        test_abort_reset();
        test_width2();
        test_width16();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
